// File: rtl/f32_to_int.sv
// Single-precision float to signed integer converter.
// Special operands (NaN, infinity, out of range, |x| < 1) resolve on the accept
// edge; in-range operands align the significand one bit per clock, collecting
// discarded bits into a sticky inexact flag. Rounding is truncation toward zero.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | ready for an operand (in_ready=1)
// SHIFT | aligning significand, one bit per clock until cnt reaches 0
// DONE  | result presented (out_valid=1), held until out_ready
module f32_to_int #(
    parameter int WIDTH         = 32,
    parameter int EXPONENTWIDTH = 8,
    parameter int MANTISSAWIDTH = 23
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_f,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_int,
    output logic [2:0]       out_flags
);

    localparam int BIAS = (1 << (EXPONENTWIDTH - 1)) - 1;
    localparam int CNTW = $clog2(WIDTH);

    // Exponent thresholds: 1.0, significand LSB weight of 1, and 2^(WIDTH-1).
    localparam logic [EXPONENTWIDTH-1:0] EXP_ONE     = EXPONENTWIDTH'(BIAS);
    localparam logic [EXPONENTWIDTH-1:0] EXP_UNIT    = EXPONENTWIDTH'(BIAS + MANTISSAWIDTH);
    localparam logic [EXPONENTWIDTH-1:0] EXP_SAT     = EXPONENTWIDTH'(BIAS + WIDTH - 1);
    localparam logic [EXPONENTWIDTH-1:0] EXP_SPECIAL = '1;

    localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] mag_q, mag_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic             left_q, left_d;
    logic             sign_q, sign_d;
    logic             sticky_q, sticky_d;
    logic [WIDTH-1:0] int_q, int_d;
    logic [2:0]       flags_q, flags_d;

    logic                     sign_f;
    logic [EXPONENTWIDTH-1:0] exp_f;
    logic [MANTISSAWIDTH-1:0] mant_f;
    logic                     mant_zero;

    assign sign_f    = in_f[WIDTH-1];
    assign exp_f     = in_f[WIDTH-2 -: EXPONENTWIDTH];
    assign mant_f    = in_f[MANTISSAWIDTH-1:0];
    assign mant_zero = (mant_f == '0);

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign out_int   = int_q;
    assign out_flags = flags_q;

    // Next-state: classify at accept, serial alignment in SHIFT, hold in DONE.
    always_comb begin
        state_d  = state_q;
        mag_d    = mag_q;
        cnt_d    = cnt_q;
        left_d   = left_q;
        sign_d   = sign_q;
        sticky_d = sticky_q;
        int_d    = int_q;
        flags_d  = flags_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    sign_d   = sign_f;
                    sticky_d = 1'b0;
                    state_d  = S_DONE;
                    if (exp_f == EXP_SPECIAL && !mant_zero) begin
                        int_d   = MIN_NEG;
                        flags_d = 3'b100;
                    end else if (exp_f >= EXP_SAT) begin
                        // -2^(WIDTH-1) is exactly representable; everything else here overflows.
                        if (sign_f && exp_f == EXP_SAT && mant_zero) begin
                            int_d   = MIN_NEG;
                            flags_d = 3'b000;
                        end else begin
                            int_d   = sign_f ? MIN_NEG : MAX_POS;
                            flags_d = 3'b010;
                        end
                    end else if (exp_f < EXP_ONE) begin
                        int_d   = '0;
                        flags_d = {2'b00, (exp_f != '0) || !mant_zero};
                    end else begin
                        mag_d   = WIDTH'({1'b1, mant_f});
                        state_d = S_SHIFT;
                        if (exp_f >= EXP_UNIT) begin
                            left_d = 1'b1;
                            cnt_d  = CNTW'(exp_f - EXP_UNIT);
                        end else begin
                            left_d = 1'b0;
                            cnt_d  = CNTW'(EXP_UNIT - exp_f);
                        end
                    end
                end
            end
            S_SHIFT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNTW'(1);
                    if (left_q) begin
                        mag_d = mag_q << 1;
                    end else begin
                        mag_d    = mag_q >> 1;
                        sticky_d = sticky_q | mag_q[0];
                    end
                end else begin
                    int_d   = sign_q ? -mag_q : mag_q;
                    flags_d = {2'b00, sticky_q};
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers; synchronous reset discards any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            mag_q    <= '0;
            cnt_q    <= '0;
            left_q   <= 1'b0;
            sign_q   <= 1'b0;
            sticky_q <= 1'b0;
            int_q    <= '0;
            flags_q  <= 3'b000;
        end else begin
            state_q  <= state_d;
            mag_q    <= mag_d;
            cnt_q    <= cnt_d;
            left_q   <= left_d;
            sign_q   <= sign_d;
            sticky_q <= sticky_d;
            int_q    <= int_d;
            flags_q  <= flags_d;
        end
    end

endmodule

// File: tb/tb_f32_to_int.sv
// Bench for f32_to_int: directed and random operands, checked every cycle
// against an arithmetic model of float-to-int truncation.
module tb_f32_to_int;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_f;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_int;
    logic [2:0]  out_flags;

    int tests = 0;
    int fails = 0;

    f32_to_int dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_f      (in_f),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_int   (out_int),
        .out_flags (out_flags)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        tests++;
        if (act !== exp_v) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    task automatic fail_now(input string name);
        tests++;
        fails++;
        $display("FAIL %s: bound expired (t=%0t)", name, $time);
    endtask

    // Reference: value = 1.m * 2^(e-127), truncated toward zero, with saturation.
    function automatic void model(input logic [31:0] f, output logic [31:0] r,
                                  output logic [2:0] fl, output int lat);
        int          e;
        logic        s;
        logic [22:0] m;
        longint unsigned sig, mag;
        s = f[31];
        e = int'(f[30:23]);
        m = f[22:0];
        lat = 0;
        fl = 3'b000;
        r = 32'h0;
        if (e == 255 && m != 0) begin
            r = 32'h8000_0000;
            fl = 3'b100;
        end else if (e >= 158) begin
            if (s && e == 158 && m == 0) begin
                r = 32'h8000_0000;
                fl = 3'b000;
            end else begin
                r = s ? 32'h8000_0000 : 32'h7FFF_FFFF;
                fl = 3'b010;
            end
        end else if (e < 127) begin
            r = 32'h0;
            fl = {2'b00, (e != 0) || (m != 0)};
        end else begin
            sig = 64'h80_0000 | 64'(m);
            if (e >= 150) begin
                mag = sig << (e - 150);
                lat = e - 150 + 1;
            end else begin
                mag = sig >> (150 - e);
                fl = {2'b00, (sig % (64'd1 << (150 - e))) != 0};
                lat = 150 - e + 1;
            end
            r = s ? -mag[31:0] : mag[31:0];
        end
    endfunction

    // Monitor/scoreboard: one in-flight operand, checked at every negedge.
    int          edge_n = 0;
    bit          pending = 0;
    bit          seen_valid = 0;
    bit          expect_idle = 0;
    int          acc_edge = 0;
    logic [31:0] exp_int;
    logic [2:0]  exp_fl;
    int          exp_lat;
    logic [31:0] last_int = 0;
    logic [2:0]  last_fl = 0;

    always @(posedge clk) edge_n++;

    always @(negedge clk) begin
        if (pending) begin
            if (out_valid) begin
                check("out_int", out_int, exp_int);
                check("out_flags", 32'(out_flags), 32'(exp_fl));
                check("ready_in_done", 32'(in_ready), 32'd0);
                if (!seen_valid) begin
                    check("latency", 32'(edge_n - acc_edge), 32'(exp_lat));
                    seen_valid = 1;
                end
                if (out_ready) begin
                    pending = 0;
                    last_int = out_int;
                    last_fl = out_flags;
                    expect_idle = 1;
                end
            end else begin
                check("ready_in_shift", 32'(in_ready), 32'd0);
                check("retain_int", out_int, last_int);
                check("retain_flags", 32'(out_flags), 32'(last_fl));
                if (edge_n - acc_edge > 40) begin
                    fail_now("result_timeout");
                    pending = 0;
                end
            end
        end else begin
            check("spurious_valid", 32'(out_valid), 32'd0);
            if (expect_idle) begin
                check("idle_after_handshake", 32'(in_ready), 32'd1);
                expect_idle = 0;
            end
            if (in_valid && in_ready && !rst) begin
                model(in_f, exp_int, exp_fl, exp_lat);
                pending = 1;
                seen_valid = 0;
                acc_edge = edge_n + 1;
            end
        end
        if (rst) begin
            pending = 0;
            seen_valid = 0;
            expect_idle = 0;
            last_int = 0;
            last_fl = 0;
        end
    end

    // Offer one operand and complete its output handshake.
    // rand_ready: random backpressure; otherwise hold out_ready low for 'hold' valid cycles.
    task automatic send(input logic [31:0] f, input bit rand_ready, input int hold);
        int guard;
        int held;
        bit hs;
        bit done;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!in_ready) begin
            fail_now("wait_in_ready");
            return;
        end
        in_valid = 1;
        in_f = f;
        @(posedge clk); #1;
        in_valid = 0;
        in_f = $urandom;
        held = 0;
        done = 0;
        guard = 0;
        while (!done && guard < 100) begin
            if (out_valid) begin
                out_ready = rand_ready ? 1'($urandom_range(0, 1)) : (held >= hold);
                held++;
                in_valid = 0;
            end else begin
                out_ready = 1'($urandom_range(0, 1));
                in_valid = 1'($urandom_range(0, 1));
                in_f = $urandom;
            end
            hs = out_valid && out_ready;
            @(posedge clk); #1;
            guard++;
            if (hs) done = 1;
        end
        in_valid = 0;
        out_ready = 0;
        if (!done) fail_now("handshake");
    endtask

    typedef struct {
        logic [31:0] f;
        logic [31:0] r;
        logic [2:0]  fl;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] mr;
        logic [2:0]  mfl;
        int          mlat;
        logic        s;
        logic [22:0] m;
        logic [7:0]  e;
        logic [31:0] f;

        clk = 0; rst = 1; in_valid = 0; in_f = 0; out_ready = 0;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_int", out_int, 32'd0);
        check("rst_out_flags", 32'(out_flags), 32'd0);

        vecs.push_back('{32'h3FE0_0000, 32'h0000_0001, 3'b001, 24});
        vecs.push_back('{32'hC0C0_0000, 32'hFFFF_FFFA, 3'b000, 22});
        vecs.push_back('{32'h4B00_0001, 32'h0080_0001, 3'b000, 1});
        vecs.push_back('{32'h4F00_0000, 32'h7FFF_FFFF, 3'b010, 0});
        vecs.push_back('{32'hCF00_0000, 32'h8000_0000, 3'b000, 0});
        vecs.push_back('{32'hFF80_0000, 32'h8000_0000, 3'b010, 0});
        vecs.push_back('{32'h7FFF_FFFF, 32'h8000_0000, 3'b100, 0});
        vecs.push_back('{32'h3E80_0000, 32'h0000_0000, 3'b001, 0});
        vecs.push_back('{32'h0000_0000, 32'h0000_0000, 3'b000, 0});
        vecs.push_back('{32'h4E7F_FFFF, 32'h3FFF_FFC0, 3'b000, 7});
        vecs.push_back('{32'h40A0_0000, 32'h0000_0005, 3'b000, 22});

        foreach (vecs[i]) begin
            model(vecs[i].f, mr, mfl, mlat);
            check("model_int", mr, vecs[i].r);
            check("model_flags", 32'(mfl), 32'(vecs[i].fl));
            check("model_latency", 32'(mlat), 32'(vecs[i].lat));
        end

        foreach (vecs[i]) send(vecs[i].f, 1, 0);

        // Long backpressure on a large positive result.
        send(32'h4E7F_FFFF, 0, 10);

        // Reset in the middle of a 24-cycle conversion.
        in_valid = 1;
        in_f = 32'h3FE0_0000;
        @(posedge clk); #1;
        in_valid = 0;
        repeat (4) @(posedge clk);
        #1 rst = 1;
        @(posedge clk); #1;
        rst = 0;
        check("ready_after_rst", 32'(in_ready), 32'd1);
        check("valid_after_rst", 32'(out_valid), 32'd0);
        check("int_after_rst", out_int, 32'd0);
        send(32'h40A0_0000, 1, 0);

        for (int k = 0; k < 250; k++) begin
            s = 1'($urandom_range(0, 1));
            m = 23'($urandom);
            if ($urandom_range(0, 3) == 0) m = 0;
            case ($urandom_range(0, 5))
                0: e = 8'($urandom);
                1: e = 8'($urandom_range(127, 157));
                2: e = 8'($urandom_range(120, 165));
                3: e = 8'hFF;
                4: e = 8'h00;
                default: e = 8'd158;
            endcase
            f = {s, e, m};
            send(f, ($urandom_range(0, 3) != 0), $urandom_range(0, 3));
        end

        repeat (3) @(posedge clk);
        #1;
        if (pending) fail_now("final_drain");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
